// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and the
// baud divider helper used by the receiver (and later the transmitter).
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam int         OSR        = 16;
    localparam logic [3:0] MID_SAMPLE = 4'd7;
    localparam logic [3:0] BIT_SAMPLE = 4'd15;

    // Clocks per oversample tick, floored; never below one.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OSR);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO shared by the UART RX/TX paths.
// Head word is driven combinationally from storage; count is registered.
`timescale 1ns/1ps
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are left alone when a push is dropped.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver feeding a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to expect one parity bit per frame.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD       = 1'(PARITY_ODD);

    uart_state_t state, state_n;

    logic                 rx_meta, rx_s;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [3:0]           os_cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_pend;
    logic                 mid_pt, bit_pt;
    logic                 shift, par_chk, stop_adv;
    logic                 push, fe_n;
    logic                 full, empty;

    assign tick   = (tick_cnt == DIV_LAST);
    assign mid_pt = tick & (os_cnt == MID_SAMPLE);
    assign bit_pt = tick & (os_cnt == BIT_SAMPLE);

    // Two-flop synchroniser, idling high so reset never looks like a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state and per-cycle frame controls.
    always_comb begin
        state_n  = state;
        shift    = 1'b0;
        par_chk  = 1'b0;
        stop_adv = 1'b0;
        push     = 1'b0;
        fe_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s)
                    state_n = START;
            end
            START: begin
                if (mid_pt)
                    state_n = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_pt) begin
                    shift = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_pt) begin
                    par_chk = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_pt) begin
                    if (!rx_s) begin
                        fe_n    = 1'b1;
                        state_n = BREAK;
                    end else if (stop_idx == LAST_STOP) begin
                        push    = ~par_pend;
                        state_n = IDLE;
                    end else begin
                        stop_adv = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Oversample counter restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            os_cnt <= '0;
        else if (state == IDLE || state_n != state)
            os_cnt <= '0;
        else if (tick)
            os_cnt <= os_cnt + 1'b1;
    end

    // Frame datapath: shift register, bit/stop indices, pending parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_pend <= 1'b0;
        end else begin
            if (shift)
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (state != DATA)
                bit_idx <= '0;
            else if (shift)
                bit_idx <= bit_idx + 1'b1;
            if (state != STOP)
                stop_idx <= 1'b0;
            else if (stop_adv)
                stop_idx <= 1'b1;
            if (state == IDLE)
                par_pend <= 1'b0;
            else if (par_chk && (rx_s != ((^shreg) ^ ODD)))
                par_pend <= 1'b1;
        end
    end

    // Registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= fe_n;
            overrun   <= push & full & ~(rd_en & rd_valid);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic pe_n;
    assign pe_n = (state == STOP) & bit_pt & rx_s
                & (stop_idx == LAST_STOP) & par_pend;

    // Parity failure pulse on an otherwise good frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err <= 1'b0;
        else
            parity_err <= pe_n;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign rd_valid = ~empty;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synthesizable, parametrised UART receiver with an integrated receive FIFO. It is the hardware counterpart of the team's behavioural UART bench model.
- Oversamples the asynchronous `rx` line at 16x baud and deserialises LSB-first frames of configurable width.
- Flags framing, parity and overrun errors.
- Buffers received words for the downstream consumer (e.g. the Enigma encryptor core) through a first-word-fall-through read port.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 115200: line baud rate.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits checked; legal values 1 or 2.
- PARITY_ODD, 0: parity sense when parity is compiled in. 0 = even, 1 = odd.
- FIFO_DEPTH, 16: receive FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- rx, input, 1: asynchronous serial input; idles high.
- rd_en, input, 1: pop request; ignored when rd_valid is 0.
- rd_data, output, DATA_BITS: head of the FIFO; valid only while rd_valid is 1.
- rd_valid, output, 1: FIFO not empty.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- frame_err, output, 1: one-cycle pulse when a stop bit is sampled low.
- parity_err, output, 1: one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- overrun, output, 1: one-cycle pulse when a word is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs are 0 (rd_data = 0, fifo_count = 0). The FSM enters IDLE, both synchroniser flops are set to 1, and the tick counter, oversample counter and FIFO pointers are cleared. Reset mid-frame discards the partial word; rd_valid never asserts spuriously.
- Synchroniser: rx passes through 2 flops (rx_s). All sampling uses rx_s, so detection latency is 2 clk.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer floor; DIV = 54 at the defaults.
  - A counter 0..DIV-1 emits a one-cycle `tick` on wrap.
  - The counter runs freely in every state.
- Oversample counter os_cnt (4 bits): increments on each tick; cleared on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rx_s == 0 → START; os_cnt cleared.
  - START: at tick with os_cnt == 7 (mid-bit), resample. If rx_s == 1, it was a glitch → IDLE. If rx_s == 0 → DATA, with os_cnt and bit_idx cleared.
  - DATA: each bit is sampled at tick with os_cnt == 15 (one bit-time after the mid-start point) and shifted in LSB first. After DATA_BITS samples → PARITY if compiled in, else STOP.
  - PARITY: samples 1 bit at os_cnt == 15 and compares it with the XOR of the data, inverted when PARITY_ODD = 1. A mismatch latches a pending parity flag. → STOP.
  - STOP: samples STOP_BITS bits at os_cnt == 15 each.
    - Any low stop bit: pulse frame_err, discard the word → BREAK.
    - All stop bits high: → IDLE. In the same cycle, push the word to the FIFO if no parity error is pending; otherwise pulse parity_err and discard the word.
  - BREAK: remain until rx_s == 1, then → IDLE. A held-low line produces exactly one frame_err.
- FIFO behaviour (first-word fall-through):
  - rd_data reflects the head combinationally from registered storage.
  - A pop occurs on rd_en & rd_valid.
  - A push when full with no pop in the same cycle drops the word and pulses overrun; stored contents are unchanged.
  - Push and pop in the same cycle when full: both succeed and count is unchanged.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is ignored because rd_valid was 0.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is registered and updates the cycle after the event.
- Latency: the word is visible on rd_data / rd_valid 1 clk after the final stop-bit sample.

Optional Feature:
- UART_RX_PARITY_EN defined: the PARITY state exists, one parity bit is expected per frame, and parity_err is functional.
- Undefined: the frame is start + DATA_BITS + STOP_BITS, the PARITY state is removed, and parity_err is tied 0.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - OSR = 16, MID_SAMPLE = 7, BIT_SAMPLE = 15;
  - the function computing DIV from CLK_FREQ/BAUD.
- One sub-module, uart_fifo: parametrised synchronous FWFT FIFO (WIDTH, DEPTH) with push/pop/full/empty/count. It is reused later by the TX side.

Test Plan:
- Defaults, rx driven with 8'h54 frames at bittime 8680 ns ×10 (no parity) → 10 words of 0x54 popped in order; no error pulses.
- 300 ns low glitch on idle rx → START aborts to IDLE; rd_valid stays 0 and no frame_err.
- Frame 0xA5 with stop bit driven low → one frame_err pulse, FIFO unchanged; after rx returns high, the next 0x3C is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD = 0, send 0x07 with parity 1 (correct) → the word is stored. Send 0x07 with parity 0 → parity_err pulse and the word is dropped.
- FIFO_DEPTH = 4, send 5 frames without popping → fifo_count = 4, one overrun pulse on the 5th, and the first 4 values are popped intact.
- Assert rst mid-DATA of a frame → rd_valid = 0 and fifo_count = 0; a subsequent full frame 0x81 is received correctly.
